input_route_buffer: RTL and testbench

- Per-input-port stage placed directly upstream of the unicast arbiter in the 5-port mesh router. One instance is used per port (L/N/E/S/W).
- Buffers incoming single-flit packets in a DEPTH-entry FIFO.
- Performs XY route computation on the head flit and presents a one-hot 5-bit output label plus the head data to the arbiter.
- Pops the head when the arbiter returns ready.

---
 rtl/input_route_buffer_if.sv | 31 +++
 rtl/input_route_buffer.sv | 115 +++++++++++
 tb/tb_input_route_buffer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/input_route_buffer_if.sv
// Handshake/bus bundle between an upstream flit source, one input_route_buffer,
// and the unicast arbiter.
//   valid_in/data_in : upstream flit offer
//   full/overflow    : backpressure and sticky drop flag
//   label/data_out   : one-hot route request and head flit to the arbiter
//   ready            : arbiter consumes the head
//   count            : buffer occupancy
// master: the upstream/arbiter side; slave: the buffer itself.
interface input_route_buffer_if #(
    parameter int unsigned DATASIZE = 30,
    parameter int unsigned WIDTH    = 2
);
    logic                valid_in;
    logic [DATASIZE-1:0] data_in;
    logic                full;
    logic [4:0]          label;
    logic [DATASIZE-1:0] data_out;
    logic                ready;
    logic                overflow;
    logic [WIDTH:0]      count;

    modport master (
        output valid_in, data_in, ready,
        input  full, label, data_out, overflow, count
    );

    modport slave (
        input  valid_in, data_in, ready,
        output full, label, data_out, overflow, count
    );
endinterface

// File: rtl/input_route_buffer.sv
// Per-input-port stage in front of the unicast arbiter of a 5-port mesh router.
// Buffers single-flit packets in a DEPTH-entry first-word-fall-through FIFO,
// XY-routes the head flit and presents a one-hot label ([4]=W [3]=N [2]=E
// [1]=S [0]=L) plus the head data. The head is popped when ready is high.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : input_route_buffer_if slave (valid_in, data_in, full, label,
//           data_out, ready, overflow, count)
module input_route_buffer #(
    parameter int unsigned DEPTH     = 4,  // must equal 2**WIDTH
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned DATASIZE  = 30,
    parameter int unsigned router_ID = 6,
    parameter int unsigned MESH_X    = 4,
    parameter int unsigned ID_BITS   = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    input_route_buffer_if.slave bus
);

    localparam int unsigned    CurX      = router_ID % MESH_X;
    localparam int unsigned    CurY      = router_ID / MESH_X;
    localparam logic [WIDTH:0] CountFull = (WIDTH + 1)'(DEPTH);

    localparam logic [4:0] LabelW = 5'b10000;
    localparam logic [4:0] LabelN = 5'b01000;
    localparam logic [4:0] LabelE = 5'b00100;
    localparam logic [4:0] LabelS = 5'b00010;
    localparam logic [4:0] LabelL = 5'b00001;

    logic [DATASIZE-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [DATASIZE-1:0] head;
    logic [ID_BITS-1:0]  dest;
    int unsigned         dx;
    int unsigned         dy;
    logic [4:0]          label;

    // full comes from the register only, so a pop this cycle does not admit a push.
    assign full  = (count_q == CountFull);
    assign empty = (count_q == '0);
    assign push  = bus.valid_in & ~full;
    // The arbiter holds ready high for an empty buffer; that must not pop.
    assign pop   = bus.ready & ~empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (bus.valid_in & full);

        // Pointers wrap naturally because DEPTH == 2**WIDTH.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_in;
    end

    // XY routing: resolve X first, then Y, otherwise deliver locally.
    always_comb begin
        head  = empty ? '0 : mem_q[rd_ptr_q];
        dest  = head[DATASIZE-1 -: ID_BITS];
        dx    = int'(dest) % MESH_X;
        dy    = int'(dest) / MESH_X;
        label = '0;
        if (!empty) begin
            if (dx > CurX)      label = LabelE;
            else if (dx < CurX) label = LabelW;
            else if (dy < CurY) label = LabelN;
            else if (dy > CurY) label = LabelS;
            else                label = LabelL;
        end
    end

    assign bus.full     = full;
    assign bus.label    = label;
    assign bus.data_out = head;
    assign bus.overflow = overflow_q;
    assign bus.count    = count_q;

endmodule

// File: tb/tb_input_route_buffer.sv
// Directed bench for input_route_buffer (router_ID=6: cur_x=2, cur_y=1).
module tb_input_route_buffer;

    localparam int unsigned DataSize = 30;
    localparam int unsigned Width    = 2;

    localparam logic [4:0] LW = 5'b10000;
    localparam logic [4:0] LN = 5'b01000;
    localparam logic [4:0] LE = 5'b00100;
    localparam logic [4:0] LS = 5'b00010;
    localparam logic [4:0] LL = 5'b00001;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    input_route_buffer_if #(.DATASIZE(DataSize), .WIDTH(Width)) bus ();

    input_route_buffer #(
        .DEPTH    (4),
        .WIDTH    (Width),
        .DATASIZE (DataSize),
        .router_ID(6),
        .MESH_X   (4),
        .ID_BITS  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DataSize-1:0] flit(input logic [3:0] dest, input logic [25:0] pay);
        return {dest, pay};
    endfunction

    logic [DataSize-1:0] q [8];
    logic [4:0]          lab [5];

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.ready    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_label", 32'(bus.label), 32'(5'b0));
        check("rst_data", 32'(bus.data_out), 32'h0);
        check("rst_full", 32'(bus.full), 32'h0);
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_ovf", 32'(bus.overflow), 32'h0);

        // Route each destination class, ready held high
        q[0] = flit(4'd7, 26'h11);  lab[0] = LE;
        q[1] = flit(4'd4, 26'h22);  lab[1] = LW;
        q[2] = flit(4'd2, 26'h33);  lab[2] = LN;
        q[3] = flit(4'd14, 26'h44); lab[3] = LS;
        q[4] = flit(4'd6, 26'h55);  lab[4] = LL;
        bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = q[i];
            step();
            check($sformatf("route_label%0d", i), 32'(bus.label), 32'(lab[i]));
            check($sformatf("route_data%0d", i), 32'(bus.data_out), 32'(q[i]));
            check($sformatf("route_count%0d", i), 32'(bus.count), 32'h1);
        end
        bus.valid_in = 1'b0;
        step();
        check("route_drain_count", 32'(bus.count), 32'h0);
        check("route_drain_label", 32'(bus.label), 32'h0);

        // Fill to full, overflow, then drain in order
        bus.ready = 1'b0;
        for (int i = 0; i < 4; i++) q[i] = flit(4'(i + 1), 26'(16'h100 + i));
        for (int i = 0; i < 4; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = q[i];
            step();
            check($sformatf("fill_count%0d", i), 32'(bus.count), 32'(i + 1));
            check($sformatf("fill_head%0d", i), 32'(bus.data_out), 32'(q[0]));
        end
        check("fill_full", 32'(bus.full), 32'h1);
        check("fill_ovf0", 32'(bus.overflow), 32'h0);
        bus.data_in = flit(4'd9, 26'h3ff);
        step();
        check("ovf_set", 32'(bus.overflow), 32'h1);
        check("ovf_count", 32'(bus.count), 32'h4);
        check("ovf_head", 32'(bus.data_out), 32'(q[0]));
        bus.valid_in = 1'b0;
        bus.ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_data%0d", i), 32'(bus.data_out), 32'(q[i]));
            step();
        end
        check("drain_count", 32'(bus.count), 32'h0);
        check("drain_full", 32'(bus.full), 32'h0);
        check("drain_ovf_sticky", 32'(bus.overflow), 32'h1);

        // Steady push+pop at count 2 across pointer wrap
        for (int i = 0; i < 8; i++) q[i] = flit(4'(15 - i), 26'(16'h200 + i));
        bus.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = q[i];
            step();
        end
        check("wrap_pre_count", 32'(bus.count), 32'h2);
        bus.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.data_in = q[i + 2];
            check($sformatf("wrap_data%0d", i), 32'(bus.data_out), 32'(q[i]));
            step();
            check($sformatf("wrap_count%0d", i), 32'(bus.count), 32'h2);
        end
        bus.valid_in = 1'b0;
        for (int i = 6; i < 8; i++) begin
            check($sformatf("wrap_tail%0d", i), 32'(bus.data_out), 32'(q[i]));
            step();
        end
        check("wrap_end_count", 32'(bus.count), 32'h0);

        // ready on empty buffer must not move rd_ptr
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("idle_count%0d", i), 32'(bus.count), 32'h0);
            check($sformatf("idle_label%0d", i), 32'(bus.label), 32'h0);
        end
        bus.ready    = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = flit(4'd14, 26'h5);
        step();
        check("idle_push_data", 32'(bus.data_out), 32'(flit(4'd14, 26'h5)));
        check("idle_push_label", 32'(bus.label), 32'(LS));

        // Async reset mid-cycle with three stored flits
        bus.data_in = flit(4'd1, 26'h6);
        step();
        bus.data_in = flit(4'd3, 26'h7);
        step();
        bus.valid_in = 1'b0;
        check("pre_rst_count", 32'(bus.count), 32'h3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(bus.count), 32'h0);
        check("arst_label", 32'(bus.label), 32'h0);
        check("arst_full", 32'(bus.full), 32'h0);
        check("arst_data", 32'(bus.data_out), 32'h0);
        check("arst_ovf", 32'(bus.overflow), 32'h0);
        step();
        rst_n        = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = flit(4'd4, 26'h77);
        #1;
        check("post_rst_nobypass", 32'(bus.label), 32'h0);
        step();
        bus.valid_in = 1'b0;
        check("post_rst_data", 32'(bus.data_out), 32'(flit(4'd4, 26'h77)));
        check("post_rst_label", 32'(bus.label), 32'(LW));
        check("post_rst_count", 32'(bus.count), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
